mux16_rr_arbiter: RTL and testbench
===================================

MUX16_RR_ARBITER -- requirements
Module: mux16_rr_arbiter

Interface
REQ-001 Parameter: HOLD_MAX, default 8, is the maximum number of cycles one grant is held before forced release (legal range 1..255).
REQ-002 Port: clk, input, 1, is the single clock; all state changes on its rising edge.
REQ-003 Port: rst, input, 1, is the asynchronous, active-high reset.
REQ-004 Port: req, input, 16, holds per-requester request lines for the shared 16:1 mux; bit i is requester i.
REQ-005 Port: done, input, 1, is a one-cycle release pulse from the currently granted requester.
REQ-006 Port: sel, output, 4, is the registered select driven to the 16:1 mux sel input.
REQ-007 Port: gnt, output, 16, is the registered one-hot grant, equal to 1<<sel while valid is 1, else 0.
REQ-008 Port: valid, output, 1, is 1 while a grant is active and mux output is owned by requester sel.
REQ-009 Port: timeout, output, 1, is a one-cycle pulse when a grant is force-released by HOLD_MAX.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, GRANT and GAP.
REQ-011 In IDLE with req != 0 at edge N, the block SHALL enter GRANT, with sel, gnt and valid updated at edge N (visible cycle N+1): latency 1 cycle.
REQ-012 The winner SHALL be the first set req bit searched upward from (last+1) mod 16 with wrap 15->0, where last is the 4-bit index of the previous grant.
REQ-013 In IDLE with req == 0, the block SHALL stay in IDLE with valid=0 and gnt=0, and sel SHALL hold its last value.
REQ-014 In GRANT, a 8-bit hold counter SHALL start at 1 on entry and increment each cycle the grant is held.
REQ-015 GRANT SHALL be exited to GAP on the first edge where any of the following holds: done=1, req[sel]=0, or the hold counter == HOLD_MAX.
REQ-016 On exit from GRANT, last SHALL be loaded with sel and valid/gnt SHALL deassert at the same edge.
REQ-017 timeout SHALL pulse for one cycle only when the exit is caused solely by the counter; if done=1 or req[sel]=0 on that same edge, timeout SHALL stay 0.
REQ-018 done SHALL be ignored while the state is not GRANT.
REQ-019 GAP SHALL last exactly one cycle (valid=0, gnt=0) and then enter IDLE, so back-to-back grants are separated by at least 2 idle cycles on valid.
REQ-020 A requester that stays the only one asserting SHALL be re-granted after GAP and IDLE (fairness wrap to itself).
REQ-021 Changes on req bits other than req[sel] during GRANT SHALL NOT affect the current grant.
REQ-022 gnt SHALL never have more than one bit set; valid SHALL equal |gnt at all times.

Reset
REQ-023 While rst=1, and immediately on assertion regardless of clk, the block SHALL force state=IDLE, sel=0, gnt=0, valid=0, timeout=0, hold counter=0, and last=15 (so requester 0 has top priority first).
REQ-024 A reset asserted mid-grant SHALL drop valid and gnt asynchronously, and the first arbitration after release SHALL restart from requester 0.

Verification
REQ-025 Reset release, then req=16'h0020 -> next cycle sel=5, gnt=16'h0020, valid=1; assert done for one cycle -> valid=0, one GAP cycle, then re-grant sel=5.
REQ-026 req=16'hFFFF with done pulsed in each grant's first cycle -> sel sequence 0,1,2,...,15,0, with each grant valid for 1 cycle followed by 2 cycles of valid=0.
REQ-027 HOLD_MAX=8, req=16'h0008 held without done -> valid=1 for exactly 8 cycles, timeout=1 on the cycle after the 8th, then re-grant sel=3.
REQ-028 Counter expiry and done=1 on the same edge -> single release, timeout stays 0, next winner is (sel+1) onward.
REQ-029 req=16'h8001 with last=15 after grant 15 -> next sel=0 (wrap); drop req[0] mid-grant -> release next edge, next grant sel=15.
REQ-030 rst pulsed asynchronously between clk edges during GRANT sel=9 -> valid/gnt go 0 before the next edge; after release with req=16'h0201 -> sel=0 first.

Source files
------------

// File: rtl/mux16_rr_arbiter.sv
// mux16_rr_arbiter: round-robin owner selection for a shared 16:1 mux.
// A grant is held until the owner pulses done, drops its request, or the
// hold counter reaches HOLD_MAX. Each release is followed by one GAP cycle
// and one IDLE cycle before the next arbitration.
module mux16_rr_arbiter #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    input  logic        done,
    output logic [3:0]  sel,
    output logic [15:0] gnt,
    output logic        valid,
    output logic        timeout
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_t;

    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

    state_t     state;
    logic [7:0] hold_cnt;
    logic [3:0] last;

    logic [3:0] win;
    logic       hold_expired;
    logic       owner_release;

    // Search upward from last+1; 4-bit index arithmetic provides the 15->0
    // wrap, and last itself is tried last so a lone requester is re-granted.
    function automatic logic [3:0] rr_pick(input logic [15:0] r, input logic [3:0] l);
        logic [3:0] idx;
        logic [3:0] pick;
        logic       found;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            idx = l + 4'(k);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Next winner and the release causes seen by the current owner.
    always_comb begin
        win           = rr_pick(req, last);
        hold_expired  = (hold_cnt == HOLD_LIM);
        owner_release = done || !req[sel];
    end

    // Arbitration FSM with registered select, grant, valid and timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sel      <= '0;
            gnt      <= '0;
            valid    <= 1'b0;
            timeout  <= 1'b0;
            hold_cnt <= '0;
            last     <= 4'd15;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        state    <= GRANT;
                        sel      <= win;
                        gnt      <= 16'd1 << win;
                        valid    <= 1'b1;
                        hold_cnt <= 8'd1;
                    end
                end
                GRANT: begin
                    if (owner_release || hold_expired) begin
                        state    <= GAP;
                        last     <= sel;
                        gnt      <= '0;
                        valid    <= 1'b0;
                        hold_cnt <= '0;
                        // Only a pure counter expiry is reported as a timeout.
                        timeout  <= hold_expired && !owner_release;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Directed testbench for mux16_rr_arbiter with hand-computed expectations.
module tb_mux16_rr_arbiter;

    logic        clk;
    logic        rst;
    logic [15:0] req;
    logic        done;
    logic [3:0]  sel;
    logic [15:0] gnt;
    logic        valid;
    logic        timeout;

    int n_checks = 0;
    int n_errors = 0;

    mux16_rr_arbiter #(.HOLD_MAX(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .sel     (sel),
        .gnt     (gnt),
        .valid   (valid),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_grant(input string tag, input logic [3:0] s);
        logic [15:0] one_hot;
        one_hot = 16'd1 << s;
        check_eq({tag, "_sel"}, 16'(sel), 16'(s));
        check_eq({tag, "_gnt"}, gnt, one_hot);
        check_eq({tag, "_valid"}, 16'(valid), 16'd1);
    endtask

    task automatic check_off(input string tag, input logic t);
        check_eq({tag, "_valid"}, 16'(valid), 16'd0);
        check_eq({tag, "_gnt"}, gnt, 16'h0000);
        check_eq({tag, "_timeout"}, 16'(timeout), 16'(t));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #3;
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b0;
        req  = '0;
        done = 1'b0;

        // Asynchronous reset before any clock edge
        #2;
        rst = 1'b1;
        #2;
        check_eq("rst_sel", 16'(sel), 16'd0);
        check_off("rst", 1'b0);
        tick();
        rst = 1'b0;

        // Single requester 5; done during IDLE is ignored
        req  = 16'h0020;
        done = 1'b1;
        tick();
        check_grant("r5_first", 4'd5);
        tick();
        check_off("r5_gap", 1'b0);
        done = 1'b0;
        tick();
        check_off("r5_idle", 1'b0);
        check_eq("r5_idle_sel_hold", 16'(sel), 16'd5);
        tick();
        check_grant("r5_regrant", 4'd5);
        req = '0;
        tick();
        check_off("r5_drop", 1'b0);
        tick();
        check_eq("r5_idle2_sel_hold", 16'(sel), 16'd5);

        // All requesters: rotation 0..15 then wrap to 0
        do_reset();
        req = 16'hFFFF;
        for (int k = 0; k <= 16; k++) begin
            tick();
            check_grant($sformatf("rr%0d", k), 4'(k));
            done = 1'b1;
            tick();
            check_off($sformatf("rr%0d_gap", k), 1'b0);
            done = 1'b0;
            tick();
            check_off($sformatf("rr%0d_idle", k), 1'b0);
        end

        // Hold expiry on requester 3 (last = 0)
        req = 16'h0008;
        tick();
        for (int i = 1; i <= 8; i++) begin
            check_grant($sformatf("hold%0d", i), 4'd3);
            check_eq($sformatf("hold%0d_to", i), 16'(timeout), 16'd0);
            tick();
        end
        check_off("hold_expire", 1'b1);
        tick();
        check_off("hold_idle", 1'b0);
        tick();
        check_grant("hold_regrant", 4'd3);

        // Expiry coincides with done; other req bits change mid-grant
        req = 16'h0019;
        for (int i = 0; i < 7; i++) begin
            tick();
            check_grant($sformatf("both%0d", i), 4'd3);
        end
        done = 1'b1;
        tick();
        check_off("both_release", 1'b0);
        done = 1'b0;
        tick();
        check_off("both_idle", 1'b0);
        tick();
        check_grant("both_next", 4'd4);
        req = '0;
        tick();
        check_off("both_drop", 1'b0);
        tick();

        // Wrap 15 -> 0, then request drop releases the owner
        req = 16'h8000;
        tick();
        check_grant("wrap_15", 4'd15);
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 16'h8001;
        tick();
        tick();
        check_grant("wrap_0", 4'd0);
        req = 16'h8000;
        tick();
        check_off("wrap_drop", 1'b0);
        tick();
        tick();
        check_grant("wrap_15b", 4'd15);
        req = '0;
        tick();
        tick();

        // Reset between edges during grant to requester 9
        req = 16'h0200;
        tick();
        check_grant("mid_9", 4'd9);
        #3;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_sel", 16'(sel), 16'd0);
        check_off("mid_rst", 1'b0);
        tick();
        rst = 1'b0;
        req = 16'h0201;
        tick();
        check_grant("after_rst", 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
